// File: rtl/wei_feed_ctrl_if.sv
// Status/control bundle between the weight-feed controller and the weight feeder.
// Input-named signals are feeder status; output-named signals are controller commands.
interface wei_feed_ctrl_if;
    logic i_done;
    logic i_til_done;
    logic i_fifo_full;
    logic i_fifo_empty;
    logic i_feeder_stall;
    logic i_wei_deadlock;
    logic i_pipeline_en;

    logic o_cnt_en;
    logic o_cnt_clear;
    logic o_cswitch;
    logic o_feeder_en;
    logic o_feeder_clear;
    logic o_wei_valid;
    logic o_finalpush;
    logic o_clearfifo;
    logic o_pop_en;

    modport master (
        input  i_done, i_til_done, i_fifo_full, i_fifo_empty,
               i_feeder_stall, i_wei_deadlock, i_pipeline_en,
        output o_cnt_en, o_cnt_clear, o_cswitch, o_feeder_en, o_feeder_clear,
               o_wei_valid, o_finalpush, o_clearfifo, o_pop_en
    );

    modport slave (
        output i_done, i_til_done, i_fifo_full, i_fifo_empty,
               i_feeder_stall, i_wei_deadlock, i_pipeline_en,
        input  o_cnt_en, o_cnt_clear, o_cswitch, o_feeder_en, o_feeder_clear,
               o_wei_valid, o_finalpush, o_clearfifo, o_pop_en
    );
endinterface

// File: rtl/wei_feed_ctrl.sv
// Weight-feed sequencer: clears the feeder, feeds and flushes each context in turn,
// drains the FIFO, and traps into ERROR on a sustained feeder deadlock.
module wei_feed_ctrl #(
    parameter int CTX_W      = 8,
    parameter int FLUSH_CYC  = 3,
    parameter int DL_TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CTX_W-1:0] i_ctx_total,
    wei_feed_ctrl_if.master  fb,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [CTX_W-1:0] o_ctx_cnt
);

    localparam int FL_W = $clog2(FLUSH_CYC + 1);
    localparam int DL_W = $clog2(DL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_FLUSH  = 3'd3,
        S_SWITCH = 3'd4,
        S_DRAIN  = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [FL_W-1:0]  r_flush_cnt;
    logic [DL_W-1:0]  r_dl_cnt;
    logic [CTX_W-1:0] r_ctx_cnt;

    logic             w_accept;
    logic             w_dl_state;
    logic             w_dl_trip;
    logic             w_flush_last;
    logic             w_pop;
    logic [CTX_W-1:0] w_ctx_last;
    logic             w_unused_til;

    assign w_unused_til = fb.i_til_done;
    assign w_accept     = !fb.i_fifo_full && !fb.i_feeder_stall;
    assign w_dl_state   = (r_state == S_FEED) || (r_state == S_FLUSH) || (r_state == S_DRAIN);
    // Trip on the cycle the counter would reach the timeout, so ERROR follows the last deadlock cycle.
    assign w_dl_trip    = w_dl_state && fb.i_wei_deadlock && (r_dl_cnt >= DL_W'(DL_TIMEOUT - 1));
    assign w_flush_last = w_accept && (r_flush_cnt == FL_W'(FLUSH_CYC - 1));
    assign w_ctx_last   = (i_ctx_total == {CTX_W{1'b0}}) ? {CTX_W{1'b0}} : (i_ctx_total - CTX_W'(1));
    assign w_pop        = fb.i_pipeline_en && !fb.i_fifo_empty;
    assign o_ctx_cnt    = r_ctx_cnt;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Context index, flush progress and deadlock duration counters
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ctx_cnt   <= {CTX_W{1'b0}};
            r_flush_cnt <= {FL_W{1'b0}};
            r_dl_cnt    <= {DL_W{1'b0}};
        end else begin
            if (w_next == S_CLEAR && (r_state == S_IDLE || r_state == S_ERROR)) begin
                r_ctx_cnt <= {CTX_W{1'b0}};
            end else if (r_state == S_SWITCH && w_next == S_FEED) begin
                r_ctx_cnt <= r_ctx_cnt + CTX_W'(1);
            end else begin
                r_ctx_cnt <= r_ctx_cnt;
            end

            if (w_next != S_FLUSH) begin
                r_flush_cnt <= {FL_W{1'b0}};
            end else if (r_state == S_FLUSH && w_accept) begin
                r_flush_cnt <= r_flush_cnt + FL_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end

            if (!(w_dl_state && fb.i_wei_deadlock)) begin
                r_dl_cnt <= {DL_W{1'b0}};
            end else if (r_dl_cnt < DL_W'(DL_TIMEOUT)) begin
                r_dl_cnt <= r_dl_cnt + DL_W'(1);
            end else begin
                r_dl_cnt <= r_dl_cnt;
            end
        end
    end

    // Next-state decode: abort beats deadlock, deadlock beats normal progress
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = S_IDLE;
        end else if (w_dl_trip) begin
            w_next = S_ERROR;
        end else begin
            case (r_state)
                S_IDLE:   w_next = i_start ? S_CLEAR : S_IDLE;
                S_CLEAR:  w_next = S_FEED;
                S_FEED:   w_next = (fb.i_done && w_accept) ? S_FLUSH : S_FEED;
                S_FLUSH: begin
                    if (w_flush_last) begin
                        w_next = (r_ctx_cnt == w_ctx_last) ? S_DRAIN : S_SWITCH;
                    end else begin
                        w_next = S_FLUSH;
                    end
                end
                S_SWITCH: w_next = S_FEED;
                S_DRAIN:  w_next = fb.i_fifo_empty ? S_IDLE : S_DRAIN;
                S_ERROR:  w_next = i_start ? S_CLEAR : S_ERROR;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Output decode from current state and inputs; reset forces everything low
    always_comb begin
        fb.o_cnt_en       = 1'b0;
        fb.o_cnt_clear    = 1'b0;
        fb.o_cswitch      = 1'b0;
        fb.o_feeder_en    = 1'b0;
        fb.o_feeder_clear = 1'b0;
        fb.o_wei_valid    = 1'b0;
        fb.o_finalpush    = 1'b0;
        fb.o_clearfifo    = 1'b0;
        fb.o_pop_en       = 1'b0;
        o_busy            = 1'b0;
        o_done            = 1'b0;
        o_error           = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
            end
            S_CLEAR: begin
                fb.o_cnt_clear    = 1'b1;
                fb.o_feeder_clear = 1'b1;
                fb.o_clearfifo    = 1'b1;
                o_busy            = 1'b1;
            end
            S_FEED: begin
                fb.o_cnt_en    = 1'b1;
                fb.o_feeder_en = 1'b1;
                fb.o_wei_valid = 1'b1;
                fb.o_pop_en    = w_pop;
                o_busy         = 1'b1;
            end
            S_FLUSH: begin
                fb.o_feeder_en = 1'b1;
                fb.o_finalpush = 1'b1;
                fb.o_pop_en    = w_pop;
                o_busy         = 1'b1;
            end
            S_SWITCH: begin
                fb.o_cswitch = 1'b1;
                fb.o_pop_en  = w_pop;
                o_busy       = 1'b1;
            end
            S_DRAIN: begin
                fb.o_pop_en = w_pop;
                o_busy      = 1'b1;
                o_done      = fb.i_fifo_empty && !w_dl_trip;
            end
            S_ERROR: begin
                o_error = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
        if (i_abort) begin
            fb.o_cnt_en       = 1'b0;
            fb.o_cswitch      = 1'b0;
            fb.o_feeder_en    = 1'b0;
            fb.o_wei_valid    = 1'b0;
            fb.o_finalpush    = 1'b0;
            fb.o_pop_en       = 1'b0;
            fb.o_cnt_clear    = 1'b1;
            fb.o_feeder_clear = 1'b1;
            fb.o_clearfifo    = 1'b1;
            o_done            = 1'b0;
        end else begin
            o_done = o_done;
        end
        if (!i_rstn) begin
            fb.o_cnt_en       = 1'b0;
            fb.o_cnt_clear    = 1'b0;
            fb.o_cswitch      = 1'b0;
            fb.o_feeder_en    = 1'b0;
            fb.o_feeder_clear = 1'b0;
            fb.o_wei_valid    = 1'b0;
            fb.o_finalpush    = 1'b0;
            fb.o_clearfifo    = 1'b0;
            fb.o_pop_en       = 1'b0;
            o_busy            = 1'b0;
            o_done            = 1'b0;
            o_error           = 1'b0;
        end else begin
            o_busy = o_busy;
        end
    end

endmodule

// File: tb/tb_wei_feed_ctrl.sv
// Directed, table-driven bench for wei_feed_ctrl: each vector gives one cycle of inputs
// and the state the controller is expected to be in during that cycle.
module tb_wei_feed_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       abort;
    logic [7:0] tot;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] ctx;

    always #5 clk = ~clk;

    wei_feed_ctrl_if fb ();

    wei_feed_ctrl #(.CTX_W(8), .FLUSH_CYC(3), .DL_TIMEOUT(16)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_abort     (abort),
        .i_ctx_total (tot),
        .fb          (fb),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error),
        .o_ctx_cnt   (ctx)
    );

    typedef enum {B_IDLE, B_CLEAR, B_FEED, B_FLUSH, B_SWITCH, B_DRAIN, B_ERROR} bst_t;

    typedef struct {
        logic       rstn, start, abort, done, full, empty, stall, dl, pipe;
        logic [7:0] tot;
        bst_t       st;
        logic [7:0] ctx;
        logic       dn;
    } vec_t;

    int         n_vec = 0;
    int         n_bad = 0;
    vec_t       tbl[$];
    vec_t       v;
    logic [7:0] cur_tot;

    // Control word order: cnt_en cnt_clear cswitch feeder_en feeder_clear wei_valid finalpush clearfifo pop_en
    localparam logic [8:0] P_CLR    = 9'b010010010;
    localparam logic [8:0] P_FEED   = 9'b100101000;
    localparam logic [8:0] P_FLUSH  = 9'b000100100;
    localparam logic [8:0] P_SWITCH = 9'b001000000;

    function automatic vec_t mk(bst_t st, logic [7:0] c, logic s, logic a, logic d,
                                logic f, logic e, logic stl, logic dl, logic dn);
        vec_t r;
        r.rstn = 1'b1; r.start = s; r.abort = a; r.done = d; r.full = f; r.empty = e;
        r.stall = stl; r.dl = dl; r.pipe = 1'b1; r.tot = cur_tot;
        r.st = st; r.ctx = c; r.dn = dn;
        return r;
    endfunction

    // Expected {ctrl[8:0], busy, done, error}
    function automatic logic [11:0] exp_out(vec_t x);
        logic [8:0] c;
        logic       pop;
        logic       b;
        logic       er;
        pop = x.pipe & ~x.empty;
        c = 9'd0; b = 1'b1; er = 1'b0;
        case (x.st)
            B_IDLE:   b = 1'b0;
            B_CLEAR:  c = P_CLR;
            B_FEED:   c = P_FEED   | {8'd0, pop};
            B_FLUSH:  c = P_FLUSH  | {8'd0, pop};
            B_SWITCH: c = P_SWITCH | {8'd0, pop};
            B_DRAIN:  c = {8'd0, pop};
            B_ERROR:  begin b = 1'b0; er = 1'b1; end
            default:  b = 1'b0;
        endcase
        if (x.abort) c = P_CLR;
        if (!x.rstn) return 12'd0;
        return {c, b, x.dn, er};
    endfunction

    task automatic step(input vec_t x, input string tag);
        logic [19:0] got;
        logic [19:0] want;
        @(posedge clk);
        #1;
        rstn = x.rstn; start = x.start; abort = x.abort; tot = x.tot;
        fb.i_done = x.done; fb.i_fifo_full = x.full; fb.i_fifo_empty = x.empty;
        fb.i_feeder_stall = x.stall; fb.i_wei_deadlock = x.dl; fb.i_pipeline_en = x.pipe;
        fb.i_til_done = x.done;
        @(negedge clk);
        want = {exp_out(x), x.ctx};
        got  = {fb.o_cnt_en, fb.o_cnt_clear, fb.o_cswitch, fb.o_feeder_en, fb.o_feeder_clear,
                fb.o_wei_valid, fb.o_finalpush, fb.o_clearfifo, fb.o_pop_en,
                busy, done, error, ctx};
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %b required %b", tag, n_vec, got, want);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0; tot = 8'd1;
        fb.i_done = 1'b0; fb.i_til_done = 1'b0; fb.i_fifo_full = 1'b0; fb.i_fifo_empty = 1'b0;
        fb.i_feeder_stall = 1'b0; fb.i_wei_deadlock = 1'b0; fb.i_pipeline_en = 1'b0;

        // Reset: outputs low even with abort requested
        cur_tot = 8'd1;
        v = mk(B_IDLE, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); v.rstn = 1'b0; tbl.push_back(v);

        // One context, done on 5th FEED cycle, FIFO empty on 2nd DRAIN cycle
        tbl.push_back(mk(B_IDLE,  8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_IDLE,  8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_CLEAR, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(B_FEED, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_FEED,  8'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(B_FLUSH, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_DRAIN, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_DRAIN, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(B_IDLE,  8'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));

        // Three contexts; start ignored while busy; done without accept holds FEED
        cur_tot = 8'd3;
        tbl.push_back(mk(B_IDLE,  8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_CLEAR, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_FEED,  8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_FEED,  8'd0, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_FEED,  8'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(B_FLUSH, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_SWITCH, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_FEED,  8'd1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0));
        tbl.push_back(mk(B_FEED,  8'd1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(B_FLUSH, 8'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_SWITCH, 8'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_FEED,  8'd2, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(B_FLUSH, 8'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_DRAIN, 8'd2, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(B_IDLE,  8'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));

        // ctx_total 0 acts as 1; FIFO full for 4 FLUSH cycles stretches FLUSH to 7
        cur_tot = 8'd0;
        tbl.push_back(mk(B_IDLE,  8'd2, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_CLEAR, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_FEED,  8'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_FLUSH, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        for (int i = 0; i < 4; i++) begin
            v = mk(B_FLUSH, 8'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0);
            if (i == 2) v.pipe = 1'b0;
            tbl.push_back(v);
        end
        tbl.push_back(mk(B_FLUSH, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_FLUSH, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(B_DRAIN, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1));
        tbl.push_back(mk(B_IDLE,  8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));

        foreach (tbl[i]) step(tbl[i], "table");

        // Deadlock held 16 FEED cycles -> ERROR on the 17th; restart clears the error
        cur_tot = 8'd1;
        step(mk(B_IDLE,  8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "dl_start");
        step(mk(B_CLEAR, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "dl_clear");
        for (int i = 0; i < 16; i++)
            step(mk(B_FEED, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0), "dl_hold");
        step(mk(B_ERROR, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0), "dl_error");
        step(mk(B_ERROR, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "dl_error_hold");
        step(mk(B_ERROR, 8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "dl_restart");
        step(mk(B_CLEAR, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "dl_reclear");

        // 15-cycle deadlock bursts separated by one low cycle never trip
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 15; i++)
                step(mk(B_FEED, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0), "dl_burst");
            step(mk(B_FEED, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "dl_gap");
        end
        step(mk(B_FEED, 8'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "feed_abort");
        step(mk(B_IDLE, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "feed_abort_idle");

        // Abort in SWITCH: no increment, no done; start+abort in IDLE stays IDLE
        cur_tot = 8'd2;
        step(mk(B_IDLE,  8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "sw_start");
        step(mk(B_CLEAR, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "sw_clear");
        step(mk(B_FEED,  8'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0), "sw_feed");
        for (int i = 0; i < 3; i++)
            step(mk(B_FLUSH, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "sw_flush");
        step(mk(B_SWITCH, 8'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "sw_abort");
        step(mk(B_IDLE,  8'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "start_abort");
        step(mk(B_IDLE,  8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "start_abort_idle");

        // Reset asserted mid-FEED forces everything low at once
        step(mk(B_IDLE,  8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "rst_start");
        step(mk(B_CLEAR, 8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "rst_clear");
        step(mk(B_FEED,  8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0), "rst_feed");
        v = mk(B_IDLE, 8'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0); v.rstn = 1'b0;
        step(v, "rst_mid_feed");
        step(mk(B_IDLE,  8'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0), "rst_release");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
